// File: rtl/ipml_fifo_pkg.sv
// Shared sizing helpers for the ipml FIFO family.
// Level counters need one extra bit so that a completely full FIFO is distinguishable from an empty one.
package ipml_fifo_pkg;

  localparam int PREFETCH_DEPTH = 2;

  function automatic int fifo_level_width(input int depth_width);
    return depth_width + 1;
  endfunction

  function automatic int fifo_capacity(input int depth_width);
    return 1 << depth_width;
  endfunction

endpackage

// File: rtl/ipml_sync_sdpram_v2_0.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// The array has no reset; contents survive rst and flush.
module ipml_sync_sdpram_v2_0 #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [c_ADDR_WIDTH-1:0] wr_addr,
  input  logic [c_DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [c_ADDR_WIDTH-1:0] rd_addr,
  output logic [c_DATA_WIDTH-1:0] rd_data
);

  logic [c_DATA_WIDTH-1:0] mem [0:(1<<c_ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// Single-clock first-word-fall-through FIFO: RAM storage plus a 2-entry prefetch buffer.
// water_level counts every accepted word, whether it sits in RAM, in flight, or in the buffer.
module ipml_sync_prefetch_fifo_v2_0
  import ipml_fifo_pkg::*;
#(
  parameter int c_DATA_WIDTH    = 32,
  parameter int c_DEPTH_WIDTH   = 10,
  parameter int c_AFULL_THRESH  = fifo_capacity(c_DEPTH_WIDTH) - 4,
  parameter int c_AEMPTY_THRESH = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic [c_DATA_WIDTH-1:0]                    wr_data,
  input  logic                                       wr_en,
  output logic                                       wr_vld,
  output logic [c_DATA_WIDTH-1:0]                    rd_data,
  input  logic                                       rd_en,
  output logic                                       rd_vld,
  output logic [fifo_level_width(c_DEPTH_WIDTH)-1:0] water_level,
  output logic                                       almost_full,
  output logic                                       almost_empty,
  output logic                                       wr_ovf,
  output logic                                       rd_udf
);

  localparam int LW = fifo_level_width(c_DEPTH_WIDTH);
  localparam logic [LW-1:0] CAP      = LW'(fifo_capacity(c_DEPTH_WIDTH));
  localparam logic [LW-1:0] AFULL_L  = LW'(c_AFULL_THRESH);
  localparam logic [LW-1:0] AEMPTY_L = LW'(c_AEMPTY_THRESH);

  logic [c_DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]            ram_cnt;
  logic [1:0]               pf_cnt, pf_base;
  logic [c_DATA_WIDTH-1:0]  pf_head, pf_tail, head_nxt, tail_nxt, ram_q;
  logic                     in_flight, wr_acc, pop, ram_rd;
  logic [2:0]               occ;

  assign wr_vld       = water_level < CAP;
  assign rd_vld       = pf_cnt != 2'd0;
  assign rd_data      = pf_head;
  assign almost_full  = water_level >= AFULL_L;
  assign almost_empty = water_level <= AEMPTY_L;
  assign wr_acc       = wr_en & wr_vld;
  assign pop          = rd_en & rd_vld;

  // Slots the buffer will need once the outstanding read lands; never exceed the prefetch depth.
  assign occ     = {1'b0, pf_cnt} + {2'b0, in_flight} - {2'b0, pop};
  assign ram_rd  = (ram_cnt != '0) && (occ < 3'(PREFETCH_DEPTH)) && !flush && !rst;
  assign pf_base = pf_cnt - {1'b0, pop};

  ipml_sync_sdpram_v2_0 #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_ADDR_WIDTH (c_DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc & ~flush & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_comb begin
    head_nxt = pop ? pf_tail : pf_head;
    tail_nxt = pf_tail;
    if (in_flight) begin
      if (pf_base == 2'd0) head_nxt = ram_q;
      else                 tail_nxt = ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      water_level <= '0;
      pf_cnt      <= 2'd0;
      in_flight   <= 1'b0;
      wr_ovf      <= 1'b0;
      rd_udf      <= 1'b0;
      if (rst) begin
        pf_head <= '0;
        pf_tail <= '0;
      end
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + c_DEPTH_WIDTH'(1);
      if (ram_rd) rd_ptr <= rd_ptr + c_DEPTH_WIDTH'(1);
      ram_cnt     <= ram_cnt + LW'(wr_acc) - LW'(ram_rd);
      water_level <= water_level + LW'(wr_acc) - LW'(pop);
      in_flight   <= ram_rd;
      pf_cnt      <= pf_base + 2'(in_flight);
      pf_head     <= head_nxt;
      pf_tail     <= tail_nxt;
      wr_ovf      <= wr_en & ~wr_vld;
      rd_udf      <= rd_en & ~rd_vld;
    end
  end

endmodule
